// File: rtl/fbcpu_mem_loader_pkg.sv
// Shared definitions for the FBCPU program memory / boot loader slice:
// default widths, opcode constants shared with the core, and loader state encodings.
package fbcpu_mem_loader_pkg;

    localparam int DEF_ADDRESS_WIDTH = 6;
    localparam int DEF_DATA_WIDTH    = 10;

    // Opcode field values as decoded by the core; kept here so both sides agree.
    localparam logic [3:0] OP_LOAD  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_JUMP  = 4'h4;
    localparam logic [3:0] OP_JZ    = 4'h5;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } loader_state_t;

endpackage

// File: rtl/fbcpu_ram.sv
// Synchronous read-first RAM with a registered read port (cleared on reset) and one write port.
// The read address is kept separate so the core's MAR is always what drives MDROut.
module fbcpu_ram
    import fbcpu_mem_loader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] i_raddr,
    input  logic [ADDRESS_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    input  logic                     i_we,
    output logic [DATA_WIDTH-1:0]    o_rdata
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fbcpu_mem_loader.sv
// FBCPU program memory and boot loader: streams an image into RAM while holding the core in reset.
// Optional output port enabled by defining FBCPU_OUTPORT_EN.
module fbcpu_mem_loader
    import fbcpu_mem_loader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH
`ifdef FBCPU_OUTPORT_EN
    ,
    parameter int OUT_ADDR      = 63
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic                     run_start,
    input  logic                     load_valid,
    input  logic [DATA_WIDTH-1:0]    load_data,
    input  logic                     load_last,
    output logic                     load_ready,
    output logic                     cpu_rst,
    output logic [ADDRESS_WIDTH:0]   loaded_words,
    input  logic [ADDRESS_WIDTH-1:0] MAR,
    input  logic [DATA_WIDTH-1:0]    MDRIn,
    input  logic                     RAMWr,
    output logic [DATA_WIDTH-1:0]    MDROut,
    output logic [DATA_WIDTH-1:0]    out_port,
    output logic                     out_strobe
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

    loader_state_t r_state;
    loader_state_t w_nextState;

    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [ADDRESS_WIDTH:0]   r_loadedWords;
    logic                     w_accept;
    logic                     w_lastBeat;
    logic                     w_startLoad;
    logic                     w_coreWrite;
    logic                     w_ramWe;
    logic [ADDRESS_WIDTH-1:0] w_ramWaddr;
    logic [DATA_WIDTH-1:0]    w_ramWdata;

    assign w_accept    = (r_state == ST_LOAD) && load_valid;
    assign w_lastBeat  = load_last || (r_addr == LAST_ADDR);
    assign w_startLoad = load_start && ((r_state == ST_IDLE) || (r_state == ST_RUN));
    assign w_coreWrite = (r_state == ST_RUN) && RAMWr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (load_start) begin
                    w_nextState = ST_LOAD;
                end else if (run_start) begin
                    w_nextState = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (w_accept && w_lastBeat) begin
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                if (load_start) begin
                    w_nextState = ST_LOAD;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // The address saturates at the top word; the image always ends there anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr        <= '0;
            r_loadedWords <= '0;
        end else if (w_startLoad) begin
            r_addr        <= '0;
            r_loadedWords <= '0;
        end else if (w_accept) begin
            if (r_addr != LAST_ADDR) begin
                r_addr <= r_addr + ADDRESS_WIDTH'(1);
            end
            r_loadedWords <= r_loadedWords + (ADDRESS_WIDTH + 1)'(1);
        end
    end

    assign load_ready   = (r_state == ST_LOAD);
    assign cpu_rst      = (r_state != ST_RUN);
    assign loaded_words = r_loadedWords;

    assign w_ramWe    = w_accept || w_coreWrite;
    assign w_ramWaddr = (r_state == ST_LOAD) ? r_addr    : MAR;
    assign w_ramWdata = (r_state == ST_LOAD) ? load_data : MDRIn;

    fbcpu_ram #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .i_raddr(MAR),
        .i_waddr(w_ramWaddr),
        .i_wdata(w_ramWdata),
        .i_we   (w_ramWe),
        .o_rdata(MDROut)
    );

`ifdef FBCPU_OUTPORT_EN
    logic [DATA_WIDTH-1:0] r_outPort;
    logic                  r_outStrobe;
    logic                  w_outHit;

    assign w_outHit = w_coreWrite && (MAR == ADDRESS_WIDTH'(OUT_ADDR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outPort   <= '0;
            r_outStrobe <= 1'b0;
        end else begin
            r_outStrobe <= w_outHit;
            if (w_outHit) begin
                r_outPort <= MDRIn;
            end
        end
    end

    assign out_port   = r_outPort;
    assign out_strobe = r_outStrobe;
`else
    assign out_port   = '0;
    assign out_strobe = 1'b0;
`endif

endmodule

// File: tb/tb_fbcpu_mem_loader.sv
// Directed self-checking bench for fbcpu_mem_loader: loads, gapped streams, full-depth image,
// read-first behaviour, mid-load reset, start priority and the optional output port.
module tb_fbcpu_mem_loader;

    localparam int AW = 6;
    localparam int DW = 10;

    logic          clk;
    logic          rst;
    logic          load_start;
    logic          run_start;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_last;
    logic          load_ready;
    logic          cpu_rst;
    logic [AW:0]   loaded_words;
    logic [AW-1:0] MAR;
    logic [DW-1:0] MDRIn;
    logic          RAMWr;
    logic [DW-1:0] MDROut;
    logic [DW-1:0] out_port;
    logic          out_strobe;

    int vecCount = 0;
    int errCount = 0;

    fbcpu_mem_loader dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .run_start   (run_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .cpu_rst     (cpu_rst),
        .loaded_words(loaded_words),
        .MAR         (MAR),
        .MDRIn       (MDRIn),
        .RAMWr       (RAMWr),
        .MDROut      (MDROut),
        .out_port    (out_port),
        .out_strobe  (out_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        assert (observed === expected)
        else begin
            errCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [DW-1:0] data, input logic last);
        load_valid = valid;
        load_data  = data;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic readWord(input logic [AW-1:0] addr);
        MAR = addr;
        tick();
    endtask

    initial begin
        logic pattern [10];
        int   k;

        rst        = 1'b1;
        load_start = 1'b0;
        run_start  = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        MAR        = '0;
        MDRIn      = '0;
        RAMWr      = 1'b0;
        #12;
        checkOutput("reset_cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("reset_load_ready", 32'(load_ready), 32'd0);
        checkOutput("reset_loaded_words", 32'(loaded_words), 32'd0);
        checkOutput("reset_MDROut", 32'(MDROut), 32'd0);
        checkOutput("reset_out_port", 32'(out_port), 32'd0);
        checkOutput("reset_out_strobe", 32'(out_strobe), 32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] three-word load");
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        checkOutput("t1_load_ready", 32'(load_ready), 32'd1);
        applyStimulus(1'b1, 10'h005, 1'b0);
        applyStimulus(1'b1, 10'h0C0, 1'b0);
        checkOutput("t1_cpu_rst_before_last", 32'(cpu_rst), 32'd1);
        applyStimulus(1'b1, 10'h200, 1'b1);
        checkOutput("t1_cpu_rst_after_last", 32'(cpu_rst), 32'd0);
        checkOutput("t1_load_ready_run", 32'(load_ready), 32'd0);
        checkOutput("t1_loaded_words", 32'(loaded_words), 32'd3);
        readWord(6'd0);
        checkOutput("t1_fetch_pc0", 32'(MDROut), 32'h005);
        readWord(6'd1);
        checkOutput("t1_mem1", 32'(MDROut), 32'h0C0);
        readWord(6'd2);
        checkOutput("t1_mem2", 32'(MDROut), 32'h200);

        $display("[TB] gapped valid stream");
        MAR = '0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        pattern = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        k = 0;
        for (int i = 0; i < 10; i++) begin
            if (pattern[i]) begin
                applyStimulus(1'b1, 10'(32'h100 + k), (k == 3));
                k++;
            end else begin
                applyStimulus(1'b0, 10'h3AA, 1'b0);
            end
        end
        checkOutput("t2_loaded_words", 32'(loaded_words), 32'd4);
        checkOutput("t2_cpu_rst", 32'(cpu_rst), 32'd0);
        for (int i = 0; i < 4; i++) begin
            readWord(6'(i));
            checkOutput($sformatf("t2_mem%0d", i), 32'(MDROut), 32'h100 + i);
        end

        $display("[TB] full-depth image without load_last");
        MAR = '0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 63; i++) begin
            applyStimulus(1'b1, 10'(i * 7 + 3), 1'b0);
        end
        checkOutput("t3_ready_before_64", 32'(load_ready), 32'd1);
        checkOutput("t3_cpu_rst_before_64", 32'(cpu_rst), 32'd1);
        applyStimulus(1'b1, 10'(63 * 7 + 3), 1'b0);
        checkOutput("t3_ready_after_64", 32'(load_ready), 32'd0);
        checkOutput("t3_cpu_rst_after_64", 32'(cpu_rst), 32'd0);
        checkOutput("t3_loaded_words", 32'(loaded_words), 32'd64);
        applyStimulus(1'b1, 10'h111, 1'b0);
        checkOutput("t3_beat65_loaded_words", 32'(loaded_words), 32'd64);
        checkOutput("t3_beat65_ready", 32'(load_ready), 32'd0);
        readWord(6'd0);
        checkOutput("t3_mem0", 32'(MDROut), 32'd3);
        readWord(6'd63);
        checkOutput("t3_mem63", 32'(MDROut), 32'h1BC);

        $display("[TB] read-first core write");
        MAR   = 6'd10;
        MDRIn = 10'h3FF;
        RAMWr = 1'b1;
        tick();
        RAMWr = 1'b0;
        checkOutput("t4_read_first_old", 32'(MDROut), 32'd73);
        tick();
        checkOutput("t4_read_new", 32'(MDROut), 32'h3FF);

        $display("[TB] reset in the middle of a load");
        MAR = 6'd0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        MAR   = 6'd20;
        MDRIn = 10'h2EE;
        RAMWr = 1'b1;
        applyStimulus(1'b1, 10'h0AA, 1'b0);
        applyStimulus(1'b1, 10'h055, 1'b0);
        rst = 1'b1;
        #2;
        checkOutput("t5_cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("t5_loaded_words", 32'(loaded_words), 32'd0);
        checkOutput("t5_load_ready", 32'(load_ready), 32'd0);
        rst   = 1'b0;
        RAMWr = 1'b0;
        readWord(6'd0);
        checkOutput("t5_mem0_kept", 32'(MDROut), 32'h0AA);
        readWord(6'd1);
        checkOutput("t5_mem1_kept", 32'(MDROut), 32'h055);
        readWord(6'd20);
        checkOutput("t5_core_write_ignored", 32'(MDROut), 32'd143);
        checkOutput("t5_idle_cpu_rst", 32'(cpu_rst), 32'd1);

        $display("[TB] run_start alone, then both starts together");
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        checkOutput("t6_run_start_cpu_rst", 32'(cpu_rst), 32'd0);
        checkOutput("t6_run_start_ready", 32'(load_ready), 32'd0);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        load_start = 1'b1;
        run_start  = 1'b1;
        tick();
        load_start = 1'b0;
        run_start  = 1'b0;
        checkOutput("t6_both_load_ready", 32'(load_ready), 32'd1);
        checkOutput("t6_both_cpu_rst", 32'(cpu_rst), 32'd1);
        applyStimulus(1'b1, 10'h3C3, 1'b1);
        checkOutput("t6_loaded_words", 32'(loaded_words), 32'd1);
        MAR   = 6'd63;
        MDRIn = 10'h155;
        RAMWr = 1'b1;
        tick();
        RAMWr = 1'b0;
`ifdef FBCPU_OUTPORT_EN
        checkOutput("t6_out_port", 32'(out_port), 32'h155);
        checkOutput("t6_out_strobe_hi", 32'(out_strobe), 32'd1);
`else
        checkOutput("t6_out_port_tied", 32'(out_port), 32'd0);
        checkOutput("t6_out_strobe_tied", 32'(out_strobe), 32'd0);
`endif
        tick();
        checkOutput("t6_out_strobe_lo", 32'(out_strobe), 32'd0);
        checkOutput("t6_mem63_written", 32'(MDROut), 32'h155);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
